// File: rtl/alu_req_driver.sv
// Request/response sequencer for the 8-bit combinational ALU: registers operands, waits SETTLE
// cycles, captures the result into resp_data and acc. Optional error reporting: `ALU_REQ_DRV_ERR_EN.
module alu_req_driver #(
    parameter int NBITS  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [NBITS-1:0] req_in0,
    input  logic [NBITS-1:0] req_in1,
    input  logic [2:0]       req_op,
    input  logic             req_acc,
    output logic [NBITS-1:0] alu_in0,
    output logic [NBITS-1:0] alu_in1,
    output logic [2:0]       alu_op,
    input  logic [NBITS-1:0] alu_out,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [NBITS-1:0] resp_data,
`ifdef ALU_REQ_DRV_ERR_EN
    output logic             resp_err,
`endif
    output logic [NBITS-1:0] acc
);

    generate
        if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
            $error("alu_req_driver: SETTLE must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       accept;
    logic       capture;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_rdy   = 1'b0;
        resp_val  = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_val) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_val = 1'b1;
                if (resp_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Settle counter: loaded on accept, counts down to the capture edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= SETTLE_CNT;
        end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_in0 <= '0;
            alu_in1 <= '0;
            alu_op  <= 3'd0;
        end else if (accept) begin
            alu_in0 <= req_acc ? acc : req_in0;
            alu_in1 <= req_in1;
            alu_op  <= req_op;
        end
    end

    // Result capture; acc only follows results that are reported as good.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_data <= '0;
            acc       <= '0;
`ifdef ALU_REQ_DRV_ERR_EN
            resp_err  <= 1'b0;
`endif
        end else if (capture) begin
`ifdef ALU_REQ_DRV_ERR_EN
            if (alu_op == 3'd7) begin
                resp_data <= '0;
                resp_err  <= 1'b1;
            end else begin
                resp_data <= alu_out;
                acc       <= alu_out;
                resp_err  <= 1'b0;
            end
`else
            resp_data <= alu_out;
            acc       <= alu_out;
`endif
        end
    end

endmodule

// File: tb/tb_alu_req_driver.sv
// Self-checking bench for alu_req_driver: two instances (SETTLE=1 and SETTLE=4) each driving a
// behavioural ALU, exercised by a vector table, hand-written corner sequences and random requests.
module tb_alu_req_driver;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0] req_val, req_rdy, req_acc, resp_val, resp_rdy;
    logic [7:0] req_in0 [2];
    logic [7:0] req_in1 [2];
    logic [7:0] alu_in0 [2];
    logic [7:0] alu_in1 [2];
    logic [7:0] alu_out [2];
    logic [7:0] resp_data [2];
    logic [7:0] acc [2];
    logic [2:0] req_op [2];
    logic [2:0] alu_op [2];
`ifdef ALU_REQ_DRV_ERR_EN
    logic [1:0] resp_err;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_acc [2];

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int ai, bi, r;
        ai = int'(a);
        bi = int'(b);
        case (op)
            3'd0:    r = (ai + bi) % 256;
            3'd1:    r = (ai - bi + 256) % 256;
            3'd2:    r = (ai * (1 << (bi % 8))) % 256;
            3'd3:    r = ai / (1 << (bi % 8));
            3'd4:    r = (ai < bi) ? 1 : 0;
            3'd5:    r = (ai == bi) ? 1 : 0;
            3'd6:    r = (ai > bi) ? 1 : 0;
            default: r = 0;
        endcase
        return 8'(r);
    endfunction

    always_comb alu_out[0] = alu_ref(alu_in0[0], alu_in1[0], alu_op[0]);
    always_comb alu_out[1] = alu_ref(alu_in0[1], alu_in1[1], alu_op[1]);

    alu_req_driver #(.NBITS(8), .SETTLE(1)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_val(req_val[0]), .req_rdy(req_rdy[0]), .req_in0(req_in0[0]), .req_in1(req_in1[0]),
        .req_op(req_op[0]), .req_acc(req_acc[0]),
        .alu_in0(alu_in0[0]), .alu_in1(alu_in1[0]), .alu_op(alu_op[0]), .alu_out(alu_out[0]),
        .resp_val(resp_val[0]), .resp_rdy(resp_rdy[0]), .resp_data(resp_data[0]),
`ifdef ALU_REQ_DRV_ERR_EN
        .resp_err(resp_err[0]),
`endif
        .acc(acc[0])
    );

    alu_req_driver #(.NBITS(8), .SETTLE(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_val(req_val[1]), .req_rdy(req_rdy[1]), .req_in0(req_in0[1]), .req_in1(req_in1[1]),
        .req_op(req_op[1]), .req_acc(req_acc[1]),
        .alu_in0(alu_in0[1]), .alu_in1(alu_in1[1]), .alu_op(alu_op[1]), .alu_out(alu_out[1]),
        .resp_val(resp_val[1]), .resp_rdy(resp_rdy[1]), .resp_data(resp_data[1]),
`ifdef ALU_REQ_DRV_ERR_EN
        .resp_err(resp_err[1]),
`endif
        .acc(acc[1])
    );

    function automatic int settle_of(input int d);
        return (d == 1) ? 4 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Issue one request on instance d, hold the response for 'hold' cycles, then hand it off.
    task automatic run_op(input int d, input logic [7:0] in0, input logic [7:0] in1, input logic [2:0] op,
                          input logic use_acc, input int hold, input logic [7:0] x_data, input logic [7:0] x_acc);
        logic [7:0] x_in0;
        int  cyc;
        bit  ok;
        bit  wait_ok;
        bit  hold_ok;
        x_in0 = use_acc ? exp_acc[d] : in0;
        @(negedge clk);
        req_val[d] = 1'b1;
        req_in0[d] = in0;
        req_in1[d] = in1;
        req_op[d]  = op;
        req_acc[d] = use_acc;
        resp_rdy[d] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_rdy[d]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("req_rdy_timeout", 32'd0, 32'd1);
            req_val[d] = 1'b0;
            return;
        end
        @(negedge clk);
        req_val[d] = 1'b0;
        req_in0[d] = 8'($urandom);
        req_in1[d] = 8'($urandom);
        req_op[d]  = 3'($urandom_range(0, 7));
        check("alu_in0", alu_in0[d], x_in0);
        check("alu_in1", alu_in1[d], in1);
        check("alu_op", alu_op[d], op);
        cyc = 0;
        wait_ok = 1'b1;
        while (!resp_val[d] && cyc < 40) begin
            if (req_rdy[d]) wait_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, settle_of(d));
        check("req_rdy_low_wait", wait_ok, 1'b1);
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            req_val[d] = 1'b1;
            if (!resp_val[d] || resp_data[d] !== x_data || req_rdy[d]) hold_ok = 1'b0;
            @(negedge clk);
        end
        req_val[d] = 1'b0;
        check("resp_hold", hold_ok, 1'b1);
        check("alu_in0_held", alu_in0[d], x_in0);
        check("resp_val", resp_val[d], 1'b1);
        check("resp_data", resp_data[d], x_data);
        check("acc", acc[d], x_acc);
`ifdef ALU_REQ_DRV_ERR_EN
        check("resp_err", resp_err[d], (op == 3'd7) ? 1'b1 : 1'b0);
`endif
        resp_rdy[d] = 1'b1;
        @(negedge clk);
        resp_rdy[d] = 1'b0;
        check("resp_val_after_hs", resp_val[d], 1'b0);
        check("req_rdy_after_hs", req_rdy[d], 1'b1);
        exp_acc[d] = x_acc;
    endtask

    // Expected outcome from the ALU op rules and the accumulator/error policy.
    task automatic model(input int d, input logic [7:0] in0, input logic [7:0] in1, input logic [2:0] op,
                         input logic use_acc, output logic [7:0] x_data, output logic [7:0] x_acc);
        logic [7:0] r;
        r = alu_ref(use_acc ? exp_acc[d] : in0, in1, op);
`ifdef ALU_REQ_DRV_ERR_EN
        if (op == 3'd7) begin
            x_data = 8'd0;
            x_acc  = exp_acc[d];
        end else begin
            x_data = r;
            x_acc  = r;
        end
`else
        x_data = r;
        x_acc  = r;
`endif
    endtask

    typedef struct {
        logic [7:0] in0;
        logic [7:0] in1;
        logic [2:0] op;
        logic       use_acc;
        int         hold;
        logic [7:0] x_data;
        logic [7:0] x_acc;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int accepts, resps;
        bit data_ok, quiet_ok;
        logic [7:0] xd, xa, a, b;
        logic [2:0] op;
        logic ua;
        int d, hold;

        tbl[0] = '{8'd200, 8'd100, 3'd0, 1'b0, 0, 8'd44,  8'd44};
        tbl[1] = '{8'd5,   8'd10,  3'd1, 1'b0, 0, 8'd251, 8'd251};
        tbl[2] = '{8'd0,   8'h0B,  3'd2, 1'b1, 0, 8'hD8,  8'hD8};
        tbl[3] = '{8'd200, 8'd100, 3'd0, 1'b0, 1, 8'd44,  8'd44};
`ifdef ALU_REQ_DRV_ERR_EN
        tbl[4] = '{8'd9,   8'd9,   3'd7, 1'b0, 0, 8'd0,   8'd44};
`else
        tbl[4] = '{8'd9,   8'd9,   3'd7, 1'b0, 0, 8'd0,   8'd0};
`endif
        tbl[5] = '{8'd3,   8'd5,   3'd4, 1'b0, 0, 8'd1,   8'd1};
        tbl[6] = '{8'd3,   8'd5,   3'd6, 1'b0, 2, 8'd0,   8'd0};

        reset = 1'b1;
        req_val = '0;
        req_acc = '0;
        resp_rdy = '0;
        for (int i = 0; i < 2; i++) begin
            req_in0[i] = 8'd0;
            req_in1[i] = 8'd0;
            req_op[i]  = 3'd0;
            exp_acc[i] = 8'd0;
        end
        repeat (2) @(negedge clk);
        check("rst_resp_val", resp_val, 2'b00);
        check("rst_acc", acc[0], 8'd0);
        check("rst_alu_in0", alu_in0[1], 8'd0);
        check("rst_alu_op", alu_op[0], 3'd0);
        check("rst_resp_data", resp_data[1], 8'd0);
`ifdef ALU_REQ_DRV_ERR_EN
        check("rst_resp_err", resp_err, 2'b00);
`endif
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_rdy", req_rdy, 2'b11);

        for (int i = 0; i < 7; i++) begin
            run_op(0, tbl[i].in0, tbl[i].in1, tbl[i].op, tbl[i].use_acc, tbl[i].hold, tbl[i].x_data, tbl[i].x_acc);
        end

        // SETTLE=4 with the response held off for 5 cycles while a new request waits.
        run_op(1, 8'h81, 8'h0A, 3'd3, 1'b0, 5, 8'h20, 8'h20);

        // Back-to-back requests with req_val never dropping.
        @(negedge clk);
        check("cont_idle", req_rdy[0], 1'b1);
        req_val[0] = 1'b1;
        req_in0[0] = 8'd7;
        req_in1[0] = 8'd7;
        req_op[0]  = 3'd5;
        req_acc[0] = 1'b0;
        resp_rdy[0] = 1'b1;
        accepts = 0;
        resps = 0;
        data_ok = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (req_rdy[0]) accepts++;
            if (resp_val[0]) begin
                resps++;
                if (resp_data[0] !== 8'd1) data_ok = 1'b0;
            end
            @(negedge clk);
        end
        req_val[0] = 1'b0;
        resp_rdy[0] = 1'b0;
        check("cont_accepts", accepts, 3);
        check("cont_resps", resps, 3);
        check("cont_data", data_ok, 1'b1);
        check("cont_acc", acc[0], 8'd1);
        exp_acc[0] = 8'd1;

        // Reset while instance 1 is waiting for its result.
        @(negedge clk);
        req_val[1] = 1'b1;
        req_in0[1] = 8'd3;
        req_in1[1] = 8'd4;
        req_op[1]  = 3'd0;
        req_acc[1] = 1'b0;
        resp_rdy[1] = 1'b1;
        @(negedge clk);
        req_val[1] = 1'b0;
        check("midrst_accepted", alu_in0[1], 8'd3);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_async_in0", alu_in0[1], 8'd0);
        @(negedge clk);
        reset = 1'b0;
        quiet_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_val[1]) quiet_ok = 1'b0;
        end
        resp_rdy[1] = 1'b0;
        check("midrst_no_resp", quiet_ok, 1'b1);
        check("midrst_acc", acc[1], 8'd0);
        check("midrst_alu_in1", alu_in1[1], 8'd0);
        check("midrst_alu_op", alu_op[1], 3'd0);
        check("midrst_req_rdy", req_rdy[1], 1'b1);
        exp_acc[0] = 8'd0;
        exp_acc[1] = 8'd0;

        for (int n = 0; n < 60; n++) begin
            d    = int'($urandom_range(0, 1));
            a    = 8'($urandom);
            b    = 8'($urandom);
            op   = 3'($urandom_range(0, 7));
            ua   = 1'($urandom_range(0, 1));
            hold = int'($urandom_range(0, 2));
            model(d, a, b, op, ua, xd, xa);
            run_op(d, a, b, op, ua, hold, xd, xa);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_req_driver.md
Name: alu_req_driver

Overview:
- Initiator-side sequencer for the team's 8-bit combinational ALU (op encoding: 0 add, 1 sub, 2 shl, 3 shr, 4 lt, 5 eq, 6 gt, 7 zero).
- Accepts operation requests on a val/rdy interface and drives registered operands to the ALU.
- Waits a programmable settle time, captures the result, and returns it on a val/rdy response interface.
- Keeps an accumulator so that chained operations can use the previous result as in0.

Parameters:
- NBITS, 8, datapath width of operands, ALU ports, result and accumulator.
- SETTLE, 1, cycles the ALU inputs are held before the result is sampled; legal range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_val  in  1  request valid.
- req_rdy  out  1  request ready.
- req_in0  in  NBITS  operand 0.
- req_in1  in  NBITS  operand 1.
- req_op  in  3  ALU op.
- req_acc  in  1  when 1, use the accumulator as in0 instead of req_in0.
- alu_in0  out  NBITS  registered operand to the ALU.
- alu_in1  out  NBITS  registered operand to the ALU.
- alu_op  out  3  registered op to the ALU.
- alu_out  in  NBITS  combinational ALU result.
- resp_val  out  1  response valid.
- resp_rdy  in  1  response ready.
- resp_data  out  NBITS  captured result.
- acc  out  NBITS  current accumulator value.

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - alu_in0, alu_in1, alu_op, resp_data, acc = 0.
  - Settle counter = 0, resp_val=0.
  - req_rdy=1 once reset deasserts.
- Reset mid-operation: the in-flight request is dropped, no response is produced, and the accumulator clears.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_rdy=1, resp_val=0.
    - On req_val&&req_rdy at edge E0, load alu_in0 = req_acc ? acc : req_in0, alu_in1 = req_in1, alu_op = req_op.
    - Load counter = SETTLE and go to WAIT.
  - WAIT: req_rdy=0, resp_val=0; the counter decrements each edge.
    - At the edge where counter==1, capture resp_data = alu_out, set acc = alu_out, and go to RESP.
  - RESP: resp_val=1, resp_data held stable, req_rdy=0.
    - On resp_val&&resp_rdy, go to IDLE.
    - With resp_rdy held low, stay in RESP indefinitely with data unchanged.
- Latency: request accepted at E0, result captured at E(SETTLE), resp_val visible in the cycle after E(SETTLE). With SETTLE=1, resp_val rises one cycle after acceptance.
- Throughput: at most one request outstanding. The next request is accepted no earlier than the cycle after the response handshake, giving a minimum period of SETTLE+2 cycles.
- alu_in0/alu_in1/alu_op hold their values from acceptance until the next acceptance; they do not change in RESP or IDLE.
- req_acc reads acc as of the accepting edge, i.e. the result of the most recently completed operation.
- Arithmetic: all wrap modulo 2^NBITS (ALU-defined); this block performs no arithmetic except the counter decrement.
- req_* fields are ignored when req_val=0 or req_rdy=0.
- SETTLE outside 1..15 is a configuration error; the block fails elaboration.

Optional Feature:
- Macro ALU_REQ_DRV_ERR_EN.
- When defined:
  - Adds output resp_err (1 bit, reset 0).
  - A request with req_op==7 is accepted and sequenced normally.
  - At capture, resp_err=1, resp_data=0, and acc is NOT updated.
  - For all other ops, resp_err=0.
  - resp_err is valid only while resp_val=1.
- When undefined:
  - No resp_err port.
  - op 7 is driven to the ALU like any other op; the result (0) is returned and written to acc.

Test Plan:
- Reset, then req in0=200 in1=100 op=0 with resp_rdy=1, SETTLE=1 -> resp_val one cycle after acceptance, resp_data=44, acc=44, req_rdy high again the following cycle.
- req in0=5 in1=10 op=1, then req_acc=1 in1=0x0B op=2 -> first resp_data=251, second alu_in0=251 and resp_data=0xD8 (251<<3).
- SETTLE=4, req in0=0x81 in1=0x0A op=3, resp_rdy held 0 for 5 cycles -> resp_val rises 4 cycles after acceptance, resp_data=0x20 stable, req_rdy=0 throughout, no second accept.
- req in0=7 in1=7 op=5 with req_val held high continuously -> exactly one accept per SETTLE+2 cycles, each resp_data=1.
- Assert reset while in WAIT after accepting op=0 3+4 -> resp_val never rises, acc=0, alu_* = 0, req_rdy=1 after deassert.
- With ALU_REQ_DRV_ERR_EN, acc=44 then req op=7 -> resp_err=1, resp_data=0, acc remains 44; without the macro -> resp_data=0, acc=0.
